// File: rtl/ff_tff.sv
// Positive-edge T flip-flop with asynchronous active-high reset to 0.
// Building block for the ripple-free ping-pong counter.
module ff_tff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/ff_counter_posedge.sv
// Free-running up/down (ping-pong) counter built from T flip-flops.
// Sweeps 0..MAX..0 forever; `forward` tells which way the next step goes.
module ff_counter_posedge #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] n,
    output logic             forward
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] up_en;
    logic [WIDTH-1:0] dn_en;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] n_next;
    logic             forward_next;

    // Bit i toggles counting up when all lower bits are 1, down when all are 0.
    assign up_en[0] = 1'b1;
    assign dn_en[0] = 1'b1;

    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign up_en[i] = up_en[i-1] & q[i-1];
        assign dn_en[i] = dn_en[i-1] & ~q[i-1];
    end

    assign t = forward ? up_en : dn_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_tff u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (t[i]),
            .q     (q[i])
        );
    end

    // Value the flops will hold after this edge; endpoints are detected here
    // so the direction flips on the same edge the count reaches MAX or 0.
    assign n_next = q ^ t;

    always_comb begin
        forward_next = forward;
        if (n_next == MAX) begin
            forward_next = 1'b0;
        end else if (n_next == '0) begin
            forward_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            forward <= 1'b1;
        end else begin
            forward <= forward_next;
        end
    end

    assign n = q;

endmodule

// File: tb/tb_ff_counter_posedge.sv
// Bench for ff_counter_posedge: WIDTH=3 and WIDTH=4 instances share clock and
// reset; expected (n, forward) pairs are queued per edge from a ping-pong model.
module tb_ff_counter_posedge;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] n3;
    logic       f3;
    logic [3:0] n4;
    logic       f4;

    always #5 clk = ~clk;

    ff_counter_posedge #(.WIDTH(3)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .n       (n3),
        .forward (f3)
    );

    ff_counter_posedge #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .n       (n4),
        .forward (f4)
    );

    typedef struct packed {
        logic [3:0] n;
        logic       f;
    } exp_t;

    exp_t sb3[$];
    exp_t sb4[$];
    int   k3 = 0;
    int   k4 = 0;
    int   total = 0;
    int   bad = 0;

    // Position k edges after reset in a sweep of period 2*maxv.
    function automatic exp_t model(input int k, input int maxv);
        exp_t e;
        int   p;
        p   = k % (2 * maxv);
        e.n = (p <= maxv) ? 4'(p) : 4'(2 * maxv - p);
        e.f = (p < maxv);
        return e;
    endfunction

    // Queue the expected state for the coming edge, then let the edge happen.
    task automatic advance();
        k3++;
        k4++;
        sb3.push_back(model(k3, 7));
        sb4.push_back(model(k4, 15));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (n3 !== 3'd0 || f3 !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold3 edge=%0d n=%0d f=%b want n=0 f=1", i, n3, f3);
            end
            total++;
            if (n4 !== 4'd0 || f4 !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold4 edge=%0d n=%0d f=%b want n=0 f=1", i, n4, f4);
            end
        end
        reset = 1'b0;
        k3 = 0;
        k4 = 0;
    endtask

    task automatic test_up_sweep();
        exp_t e3, e4;
        for (int i = 1; i <= 7; i++) begin
            advance();
            e3 = sb3.pop_front();
            e4 = sb4.pop_front();
            total++;
            if ({1'b0, n3} !== e3.n || f3 !== e3.f) begin
                bad++;
                $display("FAIL up_sweep3 step=%0d n=%0d f=%b want n=%0d f=%b", i, n3, f3, e3.n, e3.f);
            end
            total++;
            if (n4 !== e4.n || f4 !== e4.f) begin
                bad++;
                $display("FAIL up_sweep4 step=%0d n=%0d f=%b want n=%0d f=%b", i, n4, f4, e4.n, e4.f);
            end
        end
        total++;
        if (n3 !== 3'd7 || f3 !== 1'b0) begin
            bad++;
            $display("FAIL at_max n=%0d f=%b want n=7 f=0", n3, f3);
        end
    endtask

    task automatic test_turnaround();
        exp_t e3, e4;
        for (int i = 1; i <= 8; i++) begin
            advance();
            e3 = sb3.pop_front();
            e4 = sb4.pop_front();
            total++;
            if ({1'b0, n3} !== e3.n || f3 !== e3.f) begin
                bad++;
                $display("FAIL turnaround3 step=%0d n=%0d f=%b want n=%0d f=%b", i, n3, f3, e3.n, e3.f);
            end
            total++;
            if (n4 !== e4.n || f4 !== e4.f) begin
                bad++;
                $display("FAIL turnaround4 step=%0d n=%0d f=%b want n=%0d f=%b", i, n4, f4, e4.n, e4.f);
            end
            if (i == 7) begin
                total++;
                if (n3 !== 3'd0 || f3 !== 1'b1) begin
                    bad++;
                    $display("FAIL at_zero n=%0d f=%b want n=0 f=1", n3, f3);
                end
            end
        end
        total++;
        if (n3 !== 3'd1 || f3 !== 1'b1) begin
            bad++;
            $display("FAIL restart n=%0d f=%b want n=1 f=1", n3, f3);
        end
    endtask

    task automatic test_long_run();
        exp_t       e3, e4;
        logic [2:0] prev_n;
        logic       prev_f;
        logic [2:0] want_n;
        for (int i = 0; i < 18; i++) begin
            prev_n = n3;
            prev_f = f3;
            want_n = prev_f ? prev_n + 3'd1 : prev_n - 3'd1;
            advance();
            e3 = sb3.pop_front();
            e4 = sb4.pop_front();
            total++;
            if ({1'b0, n3} !== e3.n || f3 !== e3.f) begin
                bad++;
                $display("FAIL long_run3 step=%0d n=%0d f=%b want n=%0d f=%b", i, n3, f3, e3.n, e3.f);
            end
            total++;
            if (n4 !== e4.n || f4 !== e4.f) begin
                bad++;
                $display("FAIL long_run4 step=%0d n=%0d f=%b want n=%0d f=%b", i, n4, f4, e4.n, e4.f);
            end
            total++;
            if (n3 !== want_n || (prev_n == 3'd7 && n3 == 3'd0) || (prev_n == 3'd0 && n3 == 3'd7)) begin
                bad++;
                $display("FAIL step_rule step=%0d prev=%0d dir=%b n=%0d want %0d", i, prev_n, prev_f, n3, want_n);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e3, e4;
        bit   found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (n3 == 3'd5 && f3 == 1'b0) begin
                found = 1'b1;
            end else begin
                advance();
                e3 = sb3.pop_front();
                e4 = sb4.pop_front();
                total++;
                if ({1'b0, n3} !== e3.n || f3 !== e3.f) begin
                    bad++;
                    $display("FAIL seek3 step=%0d n=%0d f=%b want n=%0d f=%b", i, n3, f3, e3.n, e3.f);
                end
                total++;
                if (n4 !== e4.n || f4 !== e4.f) begin
                    bad++;
                    $display("FAIL seek4 step=%0d n=%0d f=%b want n=%0d f=%b", i, n4, f4, e4.n, e4.f);
                end
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL seek_down5 n=%0d f=%b want n=5 f=0 within 20 edges", n3, f3);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (n3 !== 3'd0 || f3 !== 1'b1 || n4 !== 4'd0 || f4 !== 1'b1) begin
            bad++;
            $display("FAIL async_reset n3=%0d f3=%b n4=%0d f4=%b want 0/1", n3, f3, n4, f4);
        end
        @(posedge clk);
        #1;
        total++;
        if (n3 !== 3'd0 || f3 !== 1'b1) begin
            bad++;
            $display("FAIL reset_over_edge n=%0d f=%b want n=0 f=1", n3, f3);
        end
        #2;
        reset = 1'b0;
        k3 = 0;
        k4 = 0;
        for (int i = 1; i <= 3; i++) begin
            advance();
            e3 = sb3.pop_front();
            e4 = sb4.pop_front();
            total++;
            if (n3 !== 3'(i) || f3 !== 1'b1 || {1'b0, n3} !== e3.n) begin
                bad++;
                $display("FAIL resume step=%0d n=%0d f=%b want n=%0d f=1", i, n3, f3, i);
            end
            total++;
            if (n4 !== e4.n || f4 !== e4.f) begin
                bad++;
                $display("FAIL resume4 step=%0d n=%0d f=%b want n=%0d f=%b", i, n4, f4, e4.n, e4.f);
            end
        end
    endtask

    task automatic test_width4();
        exp_t e3, e4;
        int   peaks = 0;
        for (int i = 0; i < 32; i++) begin
            advance();
            e3 = sb3.pop_front();
            e4 = sb4.pop_front();
            total++;
            if ({1'b0, n3} !== e3.n || f3 !== e3.f) begin
                bad++;
                $display("FAIL w4_run3 step=%0d n=%0d f=%b want n=%0d f=%b", i, n3, f3, e3.n, e3.f);
            end
            total++;
            if (n4 !== e4.n || f4 !== e4.f) begin
                bad++;
                $display("FAIL w4_seq step=%0d n=%0d f=%b want n=%0d f=%b", i, n4, f4, e4.n, e4.f);
            end
            if (n4 == 4'd15) begin
                peaks++;
                total++;
                if (f4 !== 1'b0) begin
                    bad++;
                    $display("FAIL w4_peak_dir step=%0d f=%b want 0", i, f4);
                end
            end
        end
        total++;
        if (peaks !== 1 && peaks !== 2) begin
            bad++;
            $display("FAIL w4_peak_count got=%0d want 1 or 2 in 32 edges", peaks);
        end
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_turnaround();
        test_long_run();
        test_async_reset();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ff_counter_posedge.md
Name: ff_counter_posedge

Overview:
- Free-running up/down ("ping-pong") binary counter built from positive-edge T flip-flops.
- Counts 0 up to 2^WIDTH-1, then back down to 0, and repeats indefinitely.
- A direction flag `forward` is exported.
- Used as a demo/timebase block; it has no enable or load inputs.

Parameters:
- WIDTH, 3, counter width in bits; the maximum count is MAX = 2^WIDTH-1. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- n  output  WIDTH  current count value, driven directly from the flip-flop outputs.
- forward  output  1  registered direction flag; 1 = next step increments, 0 = next step decrements.

Behaviour:
- Reset:
  - While reset=1, n=0 and forward=1, asynchronously; this is independent of clk.
  - Reset overrides any concurrent clock edge.
  - Reset asserted mid-sweep forces n=0, forward=1 immediately, whatever the current direction.
- Release: the first rising edge sampled with reset=0 performs the first step (0 -> 1).
- Step rule, evaluated every rising edge, no enable:
  - n_next = forward ? n+1 : n-1.
  - The direction flag updates on the same edge as the count.
  - If n_next == MAX, forward_next = 0.
  - Else if n_next == 0, forward_next = 1.
  - Otherwise forward_next = forward.
- Resulting sequence for WIDTH=3, shown as (n, forward) after each edge from reset:
  - (0,1) (1,1) (2,1) (3,1) (4,1) (5,1) (6,1) (7,0) (6,0) (5,0) (4,0) (3,0) (2,0) (1,0) (0,1) (1,1) ...
  - Period is 2*MAX = 14 edges.
- Endpoints:
  - Each endpoint value appears for exactly one cycle; there is no dwell.
  - n never wraps: 7 -> 0 and 0 -> 7 never occur.
  - forward=0 while n==MAX and forward=1 while n==0, always.
- Bit-level implementation, per bit i:
  - Each bit is a T flip-flop.
  - Up toggle condition: all bits below i are 1.
  - Down toggle condition: all bits below i are 0.
  - Bit 0 toggles every cycle.
  - The direction mux selects between the two conditions using forward.
- The forward register is a plain D flop with the same asynchronous reset (reset value 1).
- No combinational path from any input to n or forward.
- Latency: a change appears on n and forward one clock edge after the edge that causes it.

Decomposition:
- Shared package: none is needed. A localparam MAX computed from WIDTH stays local to the module.
- Sub-module ff_tff:
  - Ports: clk, reset, t, q.
  - Positive-edge T flip-flop with asynchronous active-high reset to 0.
  - Instantiated WIDTH times via generate.
- Top level contains:
  - The toggle-enable chains, built as prefix AND of q and prefix AND of ~q.
  - The direction mux.
  - The forward flop and the endpoint detection on n_next.

Test Plan:
- Reset hold: reset=1 for several edges -> n=0, forward=1 throughout; reset release at a clock edge is race-free.
- Up sweep: release reset, clock 7 edges -> n goes 1..7; forward=1 through n=6, and forward=0 on the same edge n becomes 7.
- Turnaround at max then down: continue 7 edges -> n goes 6..0, forward=0 until n=0, where forward=1; next edge gives n=1.
- Long run: clock 180 ns at 10 ns period (18 edges) -> n sequence matches the 14-cycle ping-pong; a scoreboard checks n_prev±1 consistent with forward_prev at every edge and confirms n never wraps 7<->0.
- Asynchronous reset mid-operation: assert reset between edges while counting down (n=5, forward=0) -> n=0, forward=1 immediately without a clock edge; after release, counting resumes 1, 2, ...
- Parameter check, WIDTH=4: same bench -> counts 0..15..0 with period 30; forward=0 exactly when n reaches 15.
